// File: rtl/m3ds_ahb_to_sram_wbuf.sv
// AHB-Lite slave to single-port SRAM bridge with a one-entry posted write buffer.
// Reads always own the SRAM port; writes go direct in their data phase or drain later from the buffer.
module m3ds_ahb_to_sram_wbuf #(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [3:0]    SRAMWREN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS
);

    typedef enum logic [1:0] {
        W_EMPTY = 2'd0,
        W_DATA  = 2'd1,
        W_FULL  = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        E_OK   = 2'd0,
        E_ERR1 = 2'd1,
        E_ERR2 = 2'd2
    } estate_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            3'd0:    lane_mask = 4'b0001 << addr;
            3'd1:    lane_mask = 4'b0011 << {addr[1], 1'b0};
            3'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    wstate_t        wstate_q, wstate_d;
    estate_t        estate_q, estate_d;
    logic [AW-3:0]  buf_addr_q, buf_addr_d;
    logic [3:0]     buf_lanes_q, buf_lanes_d;
    logic [31:0]    buf_data_q, buf_data_d;
    logic           rd_phase_q, rd_phase_d;
    logic [AW-3:0]  rd_addr_q, rd_addr_d;
    logic           hreadyout_q, hreadyout_d;
    logic           hresp_q, hresp_d;

    logic           valid_s, bad_s, acc_s, rd_acc_s, wr_acc_s;
    logic [AW-3:0]  word_addr_s;
    logic [3:0]     lanes_s;
    logic           sram_cs_s;
    logic [3:0]     sram_wren_s;
    logic [AW-3:0]  sram_addr_s;
    logic [31:0]    sram_wdata_s;
    logic [31:0]    hrdata_s;
    logic           unused_s;

    assign unused_s    = HTRANS[0];
    assign valid_s     = HSEL & HREADY & HTRANS[1];
    assign bad_s       = valid_s & ((HSIZE > 3'd2) |
                                    ((HSIZE == 3'd1) & HADDR[0]) |
                                    ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00)));
    assign acc_s       = valid_s & ~bad_s;
    assign rd_acc_s    = acc_s & ~HWRITE;
    assign wr_acc_s    = acc_s & HWRITE;
    assign word_addr_s = HADDR[AW-1:2];
    assign lanes_s     = lane_mask(HSIZE, HADDR[1:0]);

    // Next-state for write buffer, error FSM, read pipeline; SRAM port arbitration.
    always_comb begin
        wstate_d     = wstate_q;
        estate_d     = estate_q;
        buf_addr_d   = buf_addr_q;
        buf_lanes_d  = buf_lanes_q;
        buf_data_d   = buf_data_q;
        rd_phase_d   = rd_acc_s;
        rd_addr_d    = rd_addr_q;
        sram_cs_s    = 1'b0;
        sram_wren_s  = 4'b0000;
        sram_addr_s  = word_addr_s;
        sram_wdata_s = HWDATA;

        if (rd_acc_s) begin
            rd_addr_d = word_addr_s;
            sram_cs_s = 1'b1;
        end else begin
            case (wstate_q)
                W_DATA: begin
                    sram_cs_s   = 1'b1;
                    sram_wren_s = buf_lanes_q;
                    sram_addr_s = buf_addr_q;
                end
                W_FULL: begin
                    sram_cs_s    = 1'b1;
                    sram_wren_s  = buf_lanes_q;
                    sram_addr_s  = buf_addr_q;
                    sram_wdata_s = buf_data_q;
                end
                default: begin
                    sram_cs_s = 1'b0;
                end
            endcase
        end

        case (wstate_q)
            W_EMPTY: begin
                if (wr_acc_s) begin
                    buf_addr_d  = word_addr_s;
                    buf_lanes_d = lanes_s;
                    wstate_d    = W_DATA;
                end else begin
                    wstate_d = W_EMPTY;
                end
            end
            W_DATA: begin
                if (rd_acc_s) begin
                    buf_data_d = HWDATA;
                    wstate_d   = W_FULL;
                end else if (wr_acc_s) begin
                    buf_addr_d  = word_addr_s;
                    buf_lanes_d = lanes_s;
                    wstate_d    = W_DATA;
                end else begin
                    wstate_d = W_EMPTY;
                end
            end
            W_FULL: begin
                if (rd_acc_s) begin
                    wstate_d = W_FULL;
                end else if (wr_acc_s) begin
                    buf_addr_d  = word_addr_s;
                    buf_lanes_d = lanes_s;
                    wstate_d    = W_DATA;
                end else begin
                    wstate_d = W_EMPTY;
                end
            end
            default: begin
                wstate_d = W_EMPTY;
            end
        endcase

        case (estate_q)
            E_OK: begin
                if (bad_s) begin
                    estate_d = E_ERR1;
                end else begin
                    estate_d = E_OK;
                end
            end
            E_ERR1: begin
                estate_d = E_ERR2;
            end
            E_ERR2: begin
                if (bad_s) begin
                    estate_d = E_ERR1;
                end else begin
                    estate_d = E_OK;
                end
            end
            default: begin
                estate_d = E_OK;
            end
        endcase

        hreadyout_d = (estate_d != E_ERR1);
        hresp_d     = (estate_d != E_OK);
    end

    // Read data phase: SRAM word with pending buffered bytes forwarded over it.
    always_comb begin
        hrdata_s = 32'h0000_0000;
        if (rd_phase_q) begin
            for (int i = 0; i < 4; i++) begin
                if ((wstate_q == W_FULL) && (buf_addr_q == rd_addr_q) && buf_lanes_q[i]) begin
                    hrdata_s[8*i +: 8] = buf_data_q[8*i +: 8];
                end else begin
                    hrdata_s[8*i +: 8] = SRAMRDATA[8*i +: 8];
                end
            end
        end else begin
            hrdata_s = 32'h0000_0000;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wstate_q    <= W_EMPTY;
            estate_q    <= E_OK;
            buf_addr_q  <= '0;
            buf_lanes_q <= 4'b0000;
            buf_data_q  <= 32'h0000_0000;
            rd_phase_q  <= 1'b0;
            rd_addr_q   <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            estate_q    <= estate_d;
            buf_addr_q  <= buf_addr_d;
            buf_lanes_q <= buf_lanes_d;
            buf_data_q  <= buf_data_d;
            rd_phase_q  <= rd_phase_d;
            rd_addr_q   <= rd_addr_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Keep the SRAM idle for as long as reset is held, even if a transfer is presented.
    assign SRAMCS    = sram_cs_s & ~HRESET;
    assign SRAMWREN  = sram_wren_s & {4{~HRESET}};
    assign SRAMADDR  = sram_addr_s;
    assign SRAMWDATA = sram_wdata_s;
    assign HRDATA    = hrdata_s;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule
